// File: rtl/ltc2320_pkg.sv
// Shared constants and state encoding for the LTC2320-14 device emulator.
package ltc2320_pkg;

  localparam int unsigned LTC2320_LANES      = 8;
  localparam int unsigned LTC2320_CODE_W     = 14;
  localparam int unsigned LTC2320_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2
  } state_t;

endpackage

// File: rtl/ltc2320_emu_if.sv
// Serial ADC link: receiver (master) drives CNV_n/SCK, emulator (slave) drives SDO/CLKOUT.
interface ltc2320_emu_if;
  import ltc2320_pkg::*;

  logic                     CNV_n;
  logic                     SCK;
  logic                     CLKOUT;
  logic [LTC2320_LANES-1:0] SDO;

  modport master (output CNV_n, SCK, input SDO, CLKOUT);
  modport slave  (input CNV_n, SCK, output SDO, CLKOUT);
endinterface

// File: rtl/ltc2320_emu_lane.sv
// One SDO lane: 16-bit load/shift register, MSB driven out, zeros shifted in.
module ltc2320_emu_lane
  import ltc2320_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          shift,
  input  logic                          clear,
  input  logic [LTC2320_FRAME_BITS-1:0] din,
  output logic                          sdo
);

  logic [LTC2320_FRAME_BITS-1:0] sr;

  // Zero fill means the line naturally returns to 0 after the 16th shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr <= '0;
    else if (clear) sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {sr[LTC2320_FRAME_BITS-2:0], 1'b0};
  end

  assign sdo = sr[LTC2320_FRAME_BITS-1];

endmodule

// File: rtl/ltc2320_emu.sv
// LTC2320-14 8-lane serial ADC device emulator, synchronous to the receiver clock.
// Optional LTC2320_EMU_PATTERN_EN adds pattern_en and a frame counter test pattern.
module ltc2320_emu
  import ltc2320_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned NUM_LANES   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  ltc2320_emu_if.slave                        bus,
  input  logic [NUM_LANES*LTC2320_CODE_W-1:0] code_in,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                err
`ifdef LTC2320_EMU_PATTERN_EN
  , input  logic                              pattern_en
`endif
);

  localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int unsigned BIT_W = 5;

  state_t                    state, state_d;
  logic [CNT_W-1:0]          conv_cnt, conv_cnt_d;
  logic [BIT_W-1:0]          bit_cnt, bit_cnt_d;
  logic                      busy_d, frame_done_d, err_d;
  logic                      latch_c, load_c, shift_c, clear_c;
  logic                      cnv_q, sck_q;
  logic                      cnv_rise_c, sck_fall_c;
  logic [LTC2320_CODE_W-1:0] code_lat [NUM_LANES];
  logic [NUM_LANES-1:0]      sdo;

  assign cnv_rise_c = bus.CNV_n & ~cnv_q;
  assign sck_fall_c = ~bus.SCK & sck_q;

  // cnv_q resets high so a CNV_n already high at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnv_q      <= 1'b1;
      sck_q      <= 1'b0;
      bus.CLKOUT <= 1'b0;
    end else begin
      cnv_q      <= bus.CNV_n;
      sck_q      <= bus.SCK;
      bus.CLKOUT <= bus.SCK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      conv_cnt   <= '0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      conv_cnt   <= conv_cnt_d;
      bit_cnt    <= bit_cnt_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      err        <= err_d;
    end
  end

  // A conversion start always wins; a restart while busy or shifting is an error.
  always_comb begin
    state_d      = state;
    conv_cnt_d   = conv_cnt;
    bit_cnt_d    = bit_cnt;
    busy_d       = busy;
    frame_done_d = 1'b0;
    err_d        = err;
    latch_c      = 1'b0;
    load_c       = 1'b0;
    shift_c      = 1'b0;
    clear_c      = 1'b0;
    if (cnv_rise_c) begin
      if (state != IDLE) err_d = 1'b1;
      latch_c    = 1'b1;
      clear_c    = 1'b1;
      conv_cnt_d = '0;
      bit_cnt_d  = '0;
      busy_d     = 1'b1;
      state_d    = CONVERT;
    end else begin
      case (state)
        IDLE: ;
        CONVERT: begin
          if (sck_fall_c) err_d = 1'b1;
          if (conv_cnt == CNT_W'(CONV_CYCLES - 1)) begin
            load_c     = 1'b1;
            busy_d     = 1'b0;
            conv_cnt_d = '0;
            state_d    = SHIFT;
          end else begin
            conv_cnt_d = conv_cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (sck_fall_c) begin
            shift_c = 1'b1;
            if (bit_cnt == BIT_W'(LTC2320_FRAME_BITS - 1)) begin
              bit_cnt_d    = '0;
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              bit_cnt_d = bit_cnt + BIT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef LTC2320_EMU_PATTERN_EN
  logic [LTC2320_CODE_W-1:0] frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          frame_cnt <= '0;
    else if (latch_c) frame_cnt <= frame_cnt + LTC2320_CODE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_LANES); i++) code_lat[i] <= '0;
    end else if (latch_c) begin
      for (int i = 0; i < int'(NUM_LANES); i++)
        code_lat[i] <= pattern_en ? frame_cnt + LTC2320_CODE_W'(i)
                                  : code_in[i*LTC2320_CODE_W +: LTC2320_CODE_W];
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_LANES); i++) code_lat[i] <= '0;
    end else if (latch_c) begin
      for (int i = 0; i < int'(NUM_LANES); i++)
        code_lat[i] <= code_in[i*LTC2320_CODE_W +: LTC2320_CODE_W];
    end
  end
`endif

  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    ltc2320_emu_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .load  (load_c),
      .shift (shift_c),
      .clear (clear_c),
      .din   ({code_lat[i], 2'b00}),
      .sdo   (sdo[i])
    );
  end

  assign bus.SDO = sdo;

endmodule

// File: doc/ltc2320_emu.md
# ltc2320_emu

Device-side emulator of the LTC2320-14 8-lane serial ADC. It responds to CNV_n and SCK from the existing LTC2320 receiver driver and drives the eight SDO lanes with sampled 14-bit codes. It runs in the same 200 MHz domain as the receiver and is used for closed-loop simulation and on-target loopback of the ADC path without the physical chip.

## Interface
Parameters:
- CONV_CYCLES, 80: clk cycles from the CNV_n rising edge until the MSB is presented (400 ns). Must be less than the receiver's 90-cycle sampling wait.
- NUM_LANES, 8: SDO lanes. Fixed at 8.

Ports (clock and reset first):
- clk  in  1  200 MHz system clock. Shared with the receiver, so CNV_n and SCK are synchronous and have no synchronizers.
- rst  in  1  asynchronous, active-high reset.
- CNV_n  in  1  conversion start; rising edge starts a conversion.
- SCK  in  1  serial clock from the receiver, any of the /2, /4, /8 or /16 rates.
- SDO  out  8  serial data, lane i feeds receiver channel i+1, MSB first.
- CLKOUT  out  1  SCK echo, registered one clk.
- code_in  in  8x14  per-lane codes, flattened; lane i is at [14i+13:14i].
- busy  out  1  high while converting.
- frame_done  out  1  one-cycle pulse after the 16th SCK falling edge.
- err  out  1  sticky protocol error, cleared only by rst.
- pattern_en  in  1  present only with LTC2320_EMU_PATTERN_EN.

## Operation
- Registered history: cnv_q and sck_q.
  - rst sets cnv_q to 1, so a high CNV_n at reset release does not start a conversion.
  - rst sets sck_q to 0.
- Event detection:
  - cnv_rise = CNV_n & ~cnv_q.
  - sck_fall = ~SCK & sck_q.
- State machine:
  - IDLE -> CONVERT on cnv_rise. Latch all 8 codes, clear the conversion counter, set busy.
  - CONVERT -> SHIFT when the counter reaches CONV_CYCLES-1.
    - Load each lane shift register with {code[13:0], 2'b00}.
    - Drive the lane MSB onto SDO and clear busy.
  - SHIFT: on each sck_fall, shift left one bit and increment the 5-bit bit counter.
    - SHIFT -> IDLE on the 16th sck_fall. SDO returns to 0 and frame_done pulses.
- The receiver keeps the first 15 bits, so it sees {code, 1'b0}.
- Boundary conditions:
  - cnv_rise in CONVERT or SHIFT: set err, abort, relatch codes, restart CONVERT.
  - sck_fall in CONVERT: set err, no shift.
  - sck_fall in IDLE: ignored, SDO stays 0.
  - Simultaneous cnv_rise and sck_fall: cnv_rise wins.
- Reset values: SDO=0, CLKOUT=0, busy=0, frame_done=0, err=0, state IDLE, both counters 0.
- Reset mid-frame returns to IDLE immediately.

## Timing
- Edge t, the first edge with CNV_n=1 and cnv_q=0: codes latched, busy=1 from t.
- Edge t+CONV_CYCLES: MSB valid on SDO, busy=0.
- SCK falling at edge s is detected at edge s+1; the next bit is valid from s+1.
- The receiver samples at edge s and again at s+2 or later (/2 rate), so each bit is stable across its capture edge at every divisor.
- frame_done is high for the single cycle after the edge that processes the 16th fall.
- CLKOUT equals SCK delayed one clk.

## Configuration
- LTC2320_EMU_PATTERN_EN: defined -> the pattern_en port and a 14-bit frame counter are compiled in.
  - The counter resets to 0 and increments on each conversion start.
  - With pattern_en=1, lane i latches (counter + i) mod 2^14 instead of code_in.
  - With pattern_en=0, lanes latch code_in.
- Undefined -> no port and no counter; lanes always latch code_in.

## Structure
- Package ltc2320_pkg:
  - LTC2320_LANES=8, LTC2320_CODE_W=14, LTC2320_FRAME_BITS=16.
  - State enum: IDLE, CONVERT, SHIFT.
- Sub-module ltc2320_emu_lane: one 16-bit load/shift register with serial output, instantiated 8 times.

## Test plan
- Receiver at /2, lane0=14'h1ABC, lane7=14'h3FFF, others 0, one trigger -> receiver data1=15'h3578, data8=15'h7FFE, others 0; frame_done pulses once; err=0.
- Same codes at /4, /8 and /16 -> identical receiver data; busy high for exactly 80 cycles after the CNV_n rise.
- Second CNV_n rise 5 cycles into SHIFT with new codes lane0=14'h0001 -> err=1; the next completed frame yields data1=15'h0002.
- SCK falling edges during CONVERT -> err=1; the first captured bit is still the MSB.
- rst asserted mid-SHIFT with CNV_n held high -> SDO=0, busy=0, state IDLE; no conversion starts until CNV_n goes low then high.
- With LTC2320_EMU_PATTERN_EN and pattern_en=1, three triggers -> lane3 reports 3, 4, 5 (receiver data4 = 15'h0006, 15'h0008, 15'h000A).
